mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Consumes the ALU result (address or data) and RS2 (store data).
//  Drives a single-port data memory through a req/ready handshake and aligns/extends load data.
//  Hands a write-back result to the WB stage; stalls upstream while a memory access is outstanding.
// PARAMETERS
//  ADDR_W   32  address width (ALU result width)
//  RD_W     5   destination register index width
// PORTS
//  CLK           in   1       clock, rising edge
//  RST_N         in   1       asynchronous, active-low reset
//  VALID_IN      in   1       instruction from execute is valid this cycle
//  ALU_OUT_IN    in   ADDR_W  ALU result: effective address for load/store, else result data
//  RS2_IN        in   32      store data
//  MEM_OP_IN     in   3       funct3 width/sign code
//  LOAD_IN       in   1       instruction is a load
//  STORE_IN      in   1       instruction is a store (LOAD_IN&STORE_IN never both 1)
//  RD_IN         in   RD_W    destination register
//  STALL_OUT     out  1       upstream must hold its inputs
//  DMEM_REQ      out  1       memory request, held until DMEM_READY
//  DMEM_WE       out  1       1 = write
//  DMEM_ADDR     out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  DMEM_WDATA    out  32      lane-replicated store data
//  DMEM_WSTRB    out  4       byte-lane enables (writes only, 0 on reads)
//  DMEM_READY    in   1       memory accepted/completed request this cycle
//  DMEM_RDATA    in   32      read data, valid when DMEM_READY & ~DMEM_WE
//  WB_VALID_OUT  out  1       one-cycle pulse: WB_DATA_OUT/WB_RD_OUT valid for write-back
//  WB_DATA_OUT   out  32      write-back data
//  WB_RD_OUT     out  RD_W    write-back destination
//  MISALIGN_OUT  out  1       one-cycle misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. RST_N low in WAIT aborts immediately: DMEM_REQ drops, the pending result is discarded, no WB pulse.
//  - FSM IDLE/WAIT. STALL_OUT = (state==WAIT), from registered state only.
//  - IDLE, VALID_IN & ~LOAD_IN & ~STORE_IN: next cycle WB_VALID_OUT=1, WB_DATA_OUT=ALU_OUT_IN, WB_RD_OUT=RD_IN (latency 1).
//  - IDLE, VALID_IN & (LOAD_IN|STORE_IN): capture addr/op/rd/data, go to WAIT.
//    - Registered DMEM_* outputs: DMEM_REQ=1 from the next cycle.
//  - WAIT: DMEM_* held stable until DMEM_READY=1 is sampled, then DMEM_REQ drops and the FSM returns to IDLE.
//    - Load: WB_VALID_OUT=1 that next cycle, with aligned data.
//    - Store: WB_VALID_OUT stays 0.
//    - Minimum memory-op occupancy is 2 cycles. VALID_IN is ignored in WAIT.
//  - Store lanes, a=addr[1:0]:
//    - SB(000): WSTRB=4'b0001<<a, WDATA={4{rs2[7:0]}}
//    - SH(001): WSTRB=4'b0011<<{a[1],1'b0}, WDATA={2{rs2[15:0]}}
//    - SW(010) and codes 011/110/111: WSTRB=4'hF, WDATA=rs2
//  - Load extract, using captured a:
//    - LB(000)/LBU(100): byte a, sign-/zero-extended.
//    - LH(001)/LHU(101): half a[1], sign-/zero-extended.
//    - LW(010) and codes 011/110/111: full word.
//  - Without trap, a[0] is ignored for halfwords and a[1:0] is ignored for words.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - Misaligned means LH/LHU/SH with a[0]=1, or word access with a!=0.
//    - A misaligned access in IDLE issues no DMEM request and stays in IDLE.
//    - Next cycle: MISALIGN_OUT=1, WB_VALID_OUT=0, WB_DATA_OUT=faulting address.
//  MISALIGN_TRAP_EN undefined: MISALIGN_OUT tied 0; low address bits handled as in BEHAVIOUR.
// STRUCTURE
//  - Package mem_stage_pkg holds:
//    - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//    - FSM state encoding (ST_IDLE, ST_WAIT)
//  - Sub-module load_align (combinational): rdata[31:0], a[1:0], funct3 -> 32-bit extended result.
//  - Top module holds the FSM, capture registers, store-lane logic and output registers.
// TESTING
//  1. ALU op, VALID_IN=1, ALU_OUT_IN=32'h0000_1234, RD_IN=5
//     -> next cycle WB_VALID_OUT=1, WB_DATA_OUT=32'h0000_1234, WB_RD_OUT=5, STALL_OUT=0.
//  2. SB, addr=32'h100 + 3, RS2=32'hAABB_CCDD
//     -> DMEM_ADDR=32'h100, WSTRB=4'b1000, WDATA=32'hDDDD_DDDD, WE=1, no WB pulse.
//  3. LB, addr=32'h202, RDATA=32'h0080_0000, READY after 3 wait cycles
//     -> STALL_OUT high 4 cycles, then WB_DATA_OUT=32'hFFFF_FF80. Same access as LBU -> 32'h0000_0080.
//  4. LHU, addr=32'h302, RDATA=32'h8001_1234 -> WB_DATA_OUT=32'h0000_8001.
//     LH, addr=32'h300, same RDATA -> 32'h0000_1234.
//  5. SW issued, RST_N pulsed low during WAIT
//     -> DMEM_REQ=0 and STALL_OUT=0 immediately, FSM in IDLE, no WB pulse after release.
//  6. MISALIGN_TRAP_EN: LW at addr=32'h401 -> no DMEM_REQ, MISALIGN_OUT=1 for 1 cycle, WB_DATA_OUT=32'h401.
//     Without the macro: word read from 32'h400 with MISALIGN_OUT=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states,
// and small decode helpers.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // funct3[1] set selects a full word (010/011/110/111); 01 in the low bits is a halfword.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1])
            return a != 2'b00;
        if (f3[1:0] == F3_H[1:0])
            return a[0];
        return 1'b0;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1])
            return 4'hF;
        if (f3[1:0] == F3_H[1:0])
            return 4'b0011 << {a[1], 1'b0};
        return 4'b0001 << a;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load extraction: selects byte/half/word from the read word
// and sign- or zero-extends it according to funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_a,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_a)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

        // funct3[2] marks the unsigned variants (LBU/LHU).
        if (i_funct3[1])
            o_result = i_rdata;
        else if (i_funct3[1:0] == F3_H[1:0])
            o_result = {{16{w_half[15] & ~i_funct3[2]}}, w_half};
        else
            o_result = {{24{w_byte[7] & ~i_funct3[2]}}, w_byte};
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: IDLE/WAIT FSM driving a req/ready data memory port,
// store-lane generation and load write-back. Optional MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              VALID_IN,
    input  logic [ADDR_W-1:0] ALU_OUT_IN,
    input  logic [31:0]       RS2_IN,
    input  logic [2:0]        MEM_OP_IN,
    input  logic              LOAD_IN,
    input  logic              STORE_IN,
    input  logic [RD_W-1:0]   RD_IN,
    output logic              STALL_OUT,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [ADDR_W-1:0] DMEM_ADDR,
    output logic [31:0]       DMEM_WDATA,
    output logic [3:0]        DMEM_WSTRB,
    input  logic              DMEM_READY,
    input  logic [31:0]       DMEM_RDATA,
    output logic              WB_VALID_OUT,
    output logic [31:0]       WB_DATA_OUT,
    output logic [RD_W-1:0]   WB_RD_OUT,
    output logic              MISALIGN_OUT
);

    state_t            r_state;
    logic [1:0]        r_a;
    logic [2:0]        r_op;
    logic [RD_W-1:0]   r_rd;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic [RD_W-1:0]   r_wb_rd;

    logic              w_mem_op;
    logic              w_trap;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_data;

    assign w_mem_op = LOAD_IN | STORE_IN;

`ifdef MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(MEM_OP_IN, ALU_OUT_IN[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        if (MEM_OP_IN[1])
            w_wdata = RS2_IN;
        else if (MEM_OP_IN[1:0] == F3_H[1:0])
            w_wdata = {2{RS2_IN[15:0]}};
        else
            w_wdata = {4{RS2_IN[7:0]}};
    end

    load_align u_load_align (
        .i_rdata  (DMEM_RDATA),
        .i_a      (r_a),
        .i_funct3 (r_op),
        .o_result (w_load_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (VALID_IN && !w_mem_op) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= 32'(ALU_OUT_IN);
                        r_wb_rd    <= RD_IN;
                    end else if (VALID_IN && w_trap) begin
                        r_wb_data  <= 32'(ALU_OUT_IN);
                    end else if (VALID_IN) begin
                        r_state <= ST_WAIT;
                        r_a     <= ALU_OUT_IN[1:0];
                        r_op    <= MEM_OP_IN;
                        r_rd    <= RD_IN;
                        r_req   <= 1'b1;
                        r_we    <= STORE_IN;
                        r_addr  <= {ALU_OUT_IN[ADDR_W-1:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_wstrb <= STORE_IN ? store_strb(MEM_OP_IN, ALU_OUT_IN[1:0]) : 4'h0;
                    end
                end
                ST_WAIT: begin
                    if (DMEM_READY) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_load_data;
                            r_wb_rd    <= r_rd;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_misalign <= 1'b0;
        else
            r_misalign <= (r_state == ST_IDLE) && VALID_IN && w_mem_op && w_trap;
    end

    assign MISALIGN_OUT = r_misalign;
`else
    assign MISALIGN_OUT = 1'b0;
`endif

    assign STALL_OUT    = (r_state == ST_WAIT);
    assign DMEM_REQ     = r_req;
    assign DMEM_WE      = r_we;
    assign DMEM_ADDR    = r_addr;
    assign DMEM_WDATA   = r_wdata;
    assign DMEM_WSTRB   = r_wstrb;
    assign WB_VALID_OUT = r_wb_valid;
    assign WB_DATA_OUT  = r_wb_data;
    assign WB_RD_OUT    = r_wb_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build; trap
// checks are compiled in when MISALIGN_TRAP_EN is defined).
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        VALID_IN = 1'b0;
    logic [31:0] ALU_OUT_IN = '0;
    logic [31:0] RS2_IN = '0;
    logic [2:0]  MEM_OP_IN = '0;
    logic        LOAD_IN = 1'b0;
    logic        STORE_IN = 1'b0;
    logic [4:0]  RD_IN = '0;
    logic        STALL_OUT;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_WSTRB;
    logic        DMEM_READY = 1'b0;
    logic [31:0] DMEM_RDATA = '0;
    logic        WB_VALID_OUT;
    logic [31:0] WB_DATA_OUT;
    logic [4:0]  WB_RD_OUT;
    logic        MISALIGN_OUT;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    mem_access_stage #(.ADDR_W(32), .RD_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALID_IN(VALID_IN), .ALU_OUT_IN(ALU_OUT_IN),
        .RS2_IN(RS2_IN), .MEM_OP_IN(MEM_OP_IN), .LOAD_IN(LOAD_IN), .STORE_IN(STORE_IN),
        .RD_IN(RD_IN), .STALL_OUT(STALL_OUT), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB),
        .DMEM_READY(DMEM_READY), .DMEM_RDATA(DMEM_RDATA), .WB_VALID_OUT(WB_VALID_OUT),
        .WB_DATA_OUT(WB_DATA_OUT), .WB_RD_OUT(WB_RD_OUT), .MISALIGN_OUT(MISALIGN_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        VALID_IN = 1'b0; LOAD_IN = 1'b0; STORE_IN = 1'b0; DMEM_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        n_checks++;
        if ({STALL_OUT, DMEM_REQ, DMEM_WE, WB_VALID_OUT, MISALIGN_OUT} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {STALL_OUT, DMEM_REQ, DMEM_WE, WB_VALID_OUT, MISALIGN_OUT});
        end
        n_checks++;
        if ({DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB, WB_DATA_OUT, WB_RD_OUT} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h strb=%h wb=%h rd=%0d want all 0", DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB, WB_DATA_OUT, WB_RD_OUT);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        VALID_IN = 1'b1; ALU_OUT_IN = 32'h0000_1234; RD_IN = 5'd5;
        tick();
        VALID_IN = 1'b0;
        n_checks++;
        if ({WB_VALID_OUT, STALL_OUT} !== 2'b10) begin
            n_fail++; $display("FAIL alu_flags: wb_valid=%b stall=%b want 1 0", WB_VALID_OUT, STALL_OUT);
        end
        n_checks++;
        if (WB_DATA_OUT !== 32'h0000_1234 || WB_RD_OUT !== 5'd5) begin
            n_fail++; $display("FAIL alu_wb: data=%h rd=%0d want 00001234 5", WB_DATA_OUT, WB_RD_OUT);
        end
        tick();
        n_checks++;
        if (WB_VALID_OUT !== 1'b0) begin
            n_fail++; $display("FAIL alu_pulse: wb_valid=%b want 0", WB_VALID_OUT);
        end
    endtask

    task automatic test_back_to_back();
        VALID_IN = 1'b1; ALU_OUT_IN = 32'hCAFE_0001; RD_IN = 5'd1;
        tick();
        n_checks++;
        if (WB_VALID_OUT !== 1'b1 || WB_DATA_OUT !== 32'hCAFE_0001 || WB_RD_OUT !== 5'd1) begin
            n_fail++; $display("FAIL b2b_first: v=%b data=%h rd=%0d want 1 cafe0001 1", WB_VALID_OUT, WB_DATA_OUT, WB_RD_OUT);
        end
        ALU_OUT_IN = 32'hCAFE_0002; RD_IN = 5'd31;
        tick();
        VALID_IN = 1'b0;
        n_checks++;
        if (WB_VALID_OUT !== 1'b1 || WB_DATA_OUT !== 32'hCAFE_0002 || WB_RD_OUT !== 5'd31) begin
            n_fail++; $display("FAIL b2b_second: v=%b data=%h rd=%0d want 1 cafe0002 31", WB_VALID_OUT, WB_DATA_OUT, WB_RD_OUT);
        end
        tick();
    endtask

    // Issues a store, checks the memory-side outputs, completes it with no wait cycles.
    task automatic run_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_strb, input string name);
        VALID_IN = 1'b1; STORE_IN = 1'b1; MEM_OP_IN = op; ALU_OUT_IN = addr; RS2_IN = rs2; RD_IN = 5'd0;
        tick();
        idle_inputs();
        n_checks++;
        if ({DMEM_REQ, DMEM_WE, STALL_OUT} !== 3'b111 || DMEM_ADDR !== exp_addr) begin
            n_fail++; $display("FAIL %s_req: req/we/stall=%b addr=%h want 111 %h", name, {DMEM_REQ, DMEM_WE, STALL_OUT}, DMEM_ADDR, exp_addr);
        end
        n_checks++;
        if (DMEM_WDATA !== exp_wdata || DMEM_WSTRB !== exp_strb) begin
            n_fail++; $display("FAIL %s_lanes: wdata=%h strb=%b want %h %b", name, DMEM_WDATA, DMEM_WSTRB, exp_wdata, exp_strb);
        end
        DMEM_READY = 1'b1;
        tick();
        DMEM_READY = 1'b0;
        n_checks++;
        if ({DMEM_REQ, STALL_OUT, WB_VALID_OUT} !== 3'b000) begin
            n_fail++; $display("FAIL %s_done: req/stall/wb=%b want 000", name, {DMEM_REQ, STALL_OUT, WB_VALID_OUT});
        end
        tick();
        n_checks++;
        if (WB_VALID_OUT !== 1'b0) begin
            n_fail++; $display("FAIL %s_nowb: wb_valid=%b want 0", name, WB_VALID_OUT);
        end
    endtask

    task automatic test_stores();
        run_store(3'b000, 32'h0000_0103, 32'hAABB_CCDD, 32'h0000_0100, 32'hDDDD_DDDD, 4'b1000, "sb");
        run_store(3'b000, 32'h0000_0100, 32'h0000_0042, 32'h0000_0100, 32'h4242_4242, 4'b0001, "sb0");
        run_store(3'b001, 32'h0000_0106, 32'h1234_ABCD, 32'h0000_0104, 32'hABCD_ABCD, 4'b1100, "sh");
        run_store(3'b010, 32'h0000_0108, 32'h0BAD_F00D, 32'h0000_0108, 32'h0BAD_F00D, 4'b1111, "sw");
`ifndef MISALIGN_TRAP_EN
        run_store(3'b001, 32'h0000_0101, 32'h1234_ABCD, 32'h0000_0100, 32'hABCD_ABCD, 4'b0011, "sh_odd");
`endif
    endtask

    // Issues a load, holds READY low for 'waits' cycles, then completes and checks write-back.
    task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                            input int unsigned waits, input logic [31:0] exp, input logic [4:0] rd,
                            input string name);
        int unsigned stall_cnt;
        logic [31:0] exp_addr;
        stall_cnt = 0;
        exp_addr = {addr[31:2], 2'b00};
        VALID_IN = 1'b1; LOAD_IN = 1'b1; MEM_OP_IN = op; ALU_OUT_IN = addr; RD_IN = rd;
        tick();
        idle_inputs();
        n_checks++;
        if ({DMEM_REQ, DMEM_WE} !== 2'b10 || DMEM_WSTRB !== 4'h0 || DMEM_ADDR !== exp_addr) begin
            n_fail++; $display("FAIL %s_req: req/we=%b strb=%b addr=%h want 10 0000 %h", name, {DMEM_REQ, DMEM_WE}, DMEM_WSTRB, DMEM_ADDR, exp_addr);
        end
        for (int i = 0; i < int'(waits); i++) begin
            if (STALL_OUT) stall_cnt++;
            tick();
        end
        if (STALL_OUT) stall_cnt++;
        n_checks++;
        if (DMEM_REQ !== 1'b1 || DMEM_ADDR !== exp_addr) begin
            n_fail++; $display("FAIL %s_hold: req=%b addr=%h want 1 %h", name, DMEM_REQ, DMEM_ADDR, exp_addr);
        end
        DMEM_READY = 1'b1; DMEM_RDATA = rdata;
        tick();
        DMEM_READY = 1'b0;
        n_checks++;
        if (stall_cnt != waits + 1 || STALL_OUT !== 1'b0 || DMEM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL %s_stall: cycles=%0d stall=%b req=%b want %0d 0 0", name, stall_cnt, STALL_OUT, DMEM_REQ, waits + 1);
        end
        n_checks++;
        if (WB_VALID_OUT !== 1'b1 || WB_DATA_OUT !== exp || WB_RD_OUT !== rd) begin
            n_fail++; $display("FAIL %s_wb: v=%b data=%h rd=%0d want 1 %h %0d", name, WB_VALID_OUT, WB_DATA_OUT, WB_RD_OUT, exp, rd);
        end
        tick();
        n_checks++;
        if (WB_VALID_OUT !== 1'b0) begin
            n_fail++; $display("FAIL %s_pulse: wb_valid=%b want 0", name, WB_VALID_OUT);
        end
    endtask

    task automatic test_loads();
        run_load(3'b000, 32'h0000_0202, 32'h0080_0000, 3, 32'hFFFF_FF80, 5'd10, "lb");
        run_load(3'b100, 32'h0000_0202, 32'h0080_0000, 3, 32'h0000_0080, 5'd11, "lbu");
        run_load(3'b000, 32'h0000_0203, 32'h7F00_0000, 0, 32'h0000_007F, 5'd12, "lb_pos");
        run_load(3'b101, 32'h0000_0302, 32'h8001_1234, 1, 32'h0000_8001, 5'd13, "lhu");
        run_load(3'b001, 32'h0000_0300, 32'h8001_1234, 0, 32'h0000_1234, 5'd14, "lh");
        run_load(3'b001, 32'h0000_0302, 32'h8001_1234, 0, 32'hFFFF_8001, 5'd15, "lh_neg");
        run_load(3'b010, 32'h0000_0304, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 5'd16, "lw");
    endtask

    task automatic test_valid_ignored_in_wait();
        VALID_IN = 1'b1; LOAD_IN = 1'b1; MEM_OP_IN = 3'b010; ALU_OUT_IN = 32'h0000_0500; RD_IN = 5'd7;
        tick();
        LOAD_IN = 1'b0; ALU_OUT_IN = 32'h0000_DEAD; RD_IN = 5'd9;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (WB_VALID_OUT !== 1'b0 || STALL_OUT !== 1'b1 || DMEM_ADDR !== 32'h0000_0500) begin
                n_fail++; $display("FAIL wait_ignore: wb=%b stall=%b addr=%h want 0 1 00000500", WB_VALID_OUT, STALL_OUT, DMEM_ADDR);
            end
        end
        idle_inputs();
        DMEM_READY = 1'b1; DMEM_RDATA = 32'h1122_3344;
        tick();
        DMEM_READY = 1'b0;
        n_checks++;
        if (WB_VALID_OUT !== 1'b1 || WB_DATA_OUT !== 32'h1122_3344 || WB_RD_OUT !== 5'd7) begin
            n_fail++; $display("FAIL wait_result: v=%b data=%h rd=%0d want 1 11223344 7", WB_VALID_OUT, WB_DATA_OUT, WB_RD_OUT);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        VALID_IN = 1'b1; STORE_IN = 1'b1; MEM_OP_IN = 3'b010; ALU_OUT_IN = 32'h0000_0600; RS2_IN = 32'h5555_AAAA;
        tick();
        idle_inputs();
        n_checks++;
        if ({DMEM_REQ, STALL_OUT} !== 2'b11) begin
            n_fail++; $display("FAIL abort_pre: req/stall=%b want 11", {DMEM_REQ, STALL_OUT});
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({DMEM_REQ, STALL_OUT, WB_VALID_OUT} !== 3'b000) begin
            n_fail++; $display("FAIL abort_async: req/stall/wb=%b want 000", {DMEM_REQ, STALL_OUT, WB_VALID_OUT});
        end
        tick();
        RST_N = 1'b1;
        DMEM_READY = 1'b1;
        tick();
        DMEM_READY = 1'b0;
        n_checks++;
        if ({DMEM_REQ, STALL_OUT, WB_VALID_OUT} !== 3'b000) begin
            n_fail++; $display("FAIL abort_post: req/stall/wb=%b want 000", {DMEM_REQ, STALL_OUT, WB_VALID_OUT});
        end
        tick();
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        VALID_IN = 1'b1; LOAD_IN = 1'b1; MEM_OP_IN = 3'b010; ALU_OUT_IN = 32'h0000_0401; RD_IN = 5'd3;
        tick();
        idle_inputs();
        n_checks++;
        if ({DMEM_REQ, STALL_OUT, WB_VALID_OUT, MISALIGN_OUT} !== 4'b0001 || WB_DATA_OUT !== 32'h0000_0401) begin
            n_fail++; $display("FAIL trap: req/stall/wb/mis=%b data=%h want 0001 00000401", {DMEM_REQ, STALL_OUT, WB_VALID_OUT, MISALIGN_OUT}, WB_DATA_OUT);
        end
        tick();
        n_checks++;
        if ({DMEM_REQ, MISALIGN_OUT} !== 2'b00) begin
            n_fail++; $display("FAIL trap_pulse: req/mis=%b want 00", {DMEM_REQ, MISALIGN_OUT});
        end
`else
        run_load(3'b010, 32'h0000_0401, 32'h0102_0304, 0, 32'h0102_0304, 5'd3, "lw_odd");
        n_checks++;
        if (MISALIGN_OUT !== 1'b0) begin
            n_fail++; $display("FAIL no_trap: misalign=%b want 0", MISALIGN_OUT);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_stores();
        test_loads();
        test_valid_ignored_in_wait();
        test_reset_abort();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
